// File: rtl/fsm_arb_pkg.sv
// Shared types and helpers for the round-robin grant FSM.
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  // Ceiling log2, never below 1 so that single-value fields keep one bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned k = 0; k < 32; k++) begin
      if ((64'(1) << k) < 64'(v)) r = k + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/fsm_rr_arbiter_if.sv
// Requester-side bundle of the arbiter: requests, completions and grant status.
interface fsm_rr_arbiter_if #(
  parameter int unsigned N = 4
) ();
  localparam int unsigned IW = fsm_arb_pkg::clog2(N);

  logic [N-1:0]  req;
  logic [N-1:0]  done;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          busy;
  logic          timeout;

  modport master (output req, output done,
                  input gnt, input gnt_id, input busy, input timeout);
  modport slave  (input req, input done,
                  output gnt, output gnt_id, output busy, output timeout);
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above ptr, wrapping to 0.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IW'((32'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fsm_rr_arbiter.sv
// Three-state round-robin arbiter with registered one-hot grant.
// Optional hold-time limit enabled by defining FSM_ARB_TIMEOUT_EN.
module fsm_rr_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned HOLD_MAX = 8
) (
  input logic             clk,
  input logic             reset_n,
  fsm_rr_arbiter_if.slave bus
);

  localparam int unsigned IW = clog2(N);

  if (N < 2 || N > 16 || HOLD_MAX < 1) begin : g_param_err
    $error("fsm_rr_arbiter: N must be 2..16 and HOLD_MAX at least 1");
  end

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic          busy_q, busy_d;
  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic          owner_done_c;
  logic          owner_drop_c;
  logic          expire_c;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_done_c = bus.done[id_q];
  assign owner_drop_c = !bus.req[id_q];

`ifdef FSM_ARB_TIMEOUT_EN
  localparam int unsigned HW = clog2(HOLD_MAX + 1);
  logic [HW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
  assign expire_c = (cnt_q == HW'(HOLD_MAX));
`else
  assign expire_c = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
`ifdef FSM_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          id_d    = pick_idx;
          gnt_d   = N'(1) << pick_idx;
          busy_d  = 1'b1;
`ifdef FSM_ARB_TIMEOUT_EN
          cnt_d   = HW'(1);
`endif
        end
      end
      GRANT: begin
        if (owner_done_c || owner_drop_c || expire_c) begin
          state_d = RELEASE;
          id_d    = '0;
          gnt_d   = '0;
          busy_d  = 1'b0;
          ptr_d   = (id_q == IW'(N - 1)) ? '0 : id_q + IW'(1);
`ifdef FSM_ARB_TIMEOUT_EN
          // A completion on the expiry edge counts as a normal done.
          to_d    = expire_c && !owner_done_c;
`endif
        end else begin
`ifdef FSM_ARB_TIMEOUT_EN
          // Staying in GRANT implies cnt_q < HOLD_MAX, so this saturates.
          cnt_d   = cnt_q + HW'(1);
`endif
        end
      end
      RELEASE: state_d = IDLE;
      default: begin
        state_d = IDLE;
        id_d    = '0;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FSM_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      to_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q  <= to_d;
    end
  end
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif

  assign bus.gnt    = gnt_q;
  assign bus.gnt_id = id_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Scoreboard bench for fsm_rr_arbiter: stimulus queues expected grants, a monitor checks them.
module tb_fsm_rr_arbiter;

  localparam int unsigned N = 4;

  typedef struct {
    int id;
    int len;   // expected grant length in cycles, 0 = not checked
    int to;    // expected timeout pulse at release
    int gap;   // expected idle cycles before this grant, -1 = not checked
  } exp_t;

  logic clk;
  logic reset_n;
  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  fsm_rr_arbiter_if #(.N(N)) bus ();

  fsm_rr_arbiter #(.N(N), .HOLD_MAX(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Monitor: pops one expected record per observed grant.
  exp_t cur;
  int   in_grant = 0;
  int   len      = 0;
  int   gap      = 0;
  int   to_check = 0;

  always @(negedge clk) begin
    if (to_check != 0) begin
      chk("timeout_one_cycle", int'(bus.timeout), 0);
      to_check = 0;
    end
    if (in_grant == 0 && bus.gnt != '0) begin
      if (q.size() == 0) begin
        chk("unexpected_grant", int'(bus.gnt), 0);
      end else begin
        cur = q.pop_front();
        chk("gnt_id", int'(bus.gnt_id), cur.id);
        chk("gnt_onehot", int'(bus.gnt), 1 << cur.id);
        chk("busy_on", int'(bus.busy), 1);
        if (cur.gap >= 0) chk("idle_gap", gap, cur.gap);
      end
      in_grant = 1;
      len = 1;
    end else if (in_grant != 0 && bus.gnt != '0) begin
      len++;
    end else if (in_grant != 0) begin
      in_grant = 0;
      if (cur.len > 0) chk("grant_len", len, cur.len);
      chk("busy_off", int'(bus.busy), 0);
      chk("timeout_at_release", int'(bus.timeout), cur.to);
      to_check = 1;
      gap = 1;
    end else begin
      gap++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 20; i++) begin
      if (bus.busy) return;
      step();
    end
    chk("grant_wait_bound", int'(bus.busy), 1);
  endtask

  // Request, hold the grant for l cycles, then pulse done on the owner.
  task automatic grant_cycle(input logic [N-1:0] r, input int id, input int l,
                             input int g, input bit drop);
    exp_t e;
    e.id = id; e.len = l; e.to = 0; e.gap = g;
    q.push_back(e);
    bus.req = r;
    wait_busy();
    repeat (l - 1) step();
    bus.done = N'(1) << id;
    step();
    bus.done = '0;
    if (drop) bus.req = '0;
  endtask

  exp_t e;

  initial begin
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.done = '0;
    #3;
    chk("reset_gnt", int'(bus.gnt), 0);
    chk("reset_gnt_id", int'(bus.gnt_id), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_timeout", int'(bus.timeout), 0);
    step(); step();
    reset_n = 1'b1;
    step(); step();

    // Fairness: all requesting, each owner done after one cycle.
    grant_cycle(4'b1111, 0, 1, -1, 0);
    grant_cycle(4'b1111, 1, 1, 2, 0);
    grant_cycle(4'b1111, 2, 1, 2, 0);
    grant_cycle(4'b1111, 3, 1, 2, 0);
    grant_cycle(4'b1111, 0, 1, 2, 1);
    repeat (3) step();

    // Single request, done three cycles after grant.
    grant_cycle(4'b0100, 2, 3, -1, 1);
    repeat (3) step();

    // Wrap/skip from ptr=3.
    grant_cycle(4'b0011, 0, 2, -1, 0);
    grant_cycle(4'b0011, 1, 1, 2, 1);
    repeat (3) step();

    // Abandon: non-owner done ignored, owner drops request.
    e.id = 1; e.len = 3; e.to = 0; e.gap = -1;
    q.push_back(e);
    bus.req = 4'b0010;
    wait_busy();
    bus.done = 4'b1000;
    step();
    bus.done = '0;
    chk("ignored_done_busy", int'(bus.busy), 1);
    step();
    bus.req = '0;
    step();
    chk("abandon_released", int'(bus.busy), 0);
    repeat (3) step();

    // Asynchronous reset in the middle of owner 2's grant, ptr=2 beforehand.
    e.id = 2; e.len = 0; e.to = 0; e.gap = -1;
    q.push_back(e);
    bus.req = 4'b0100;
    wait_busy();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("midgrant_reset_gnt", int'(bus.gnt), 0);
    chk("midgrant_reset_busy", int'(bus.busy), 0);
    chk("midgrant_reset_gnt_id", int'(bus.gnt_id), 0);
    bus.req = '0;
    step(); step();
    reset_n = 1'b1;
    step();
    grant_cycle(4'b1111, 0, 1, -1, 1);
    repeat (3) step();

`ifdef FSM_ARB_TIMEOUT_EN
    // Owner never completes: grant revoked after HOLD_MAX cycles.
    e.id = 0; e.len = 8; e.to = 1; e.gap = -1;
    q.push_back(e);
    bus.req = 4'b0001;
    wait_busy();
    for (int i = 0; i < 20 && bus.busy; i++) step();
    chk("timeout_release_bound", int'(bus.busy), 0);
    bus.req = '0;
    repeat (3) step();
    // Done on the final allowed cycle wins over expiry.
    grant_cycle(4'b0001, 0, 8, -1, 1);
`else
    // Without the limit, a long grant is not revoked.
    grant_cycle(4'b0001, 0, 12, -1, 1);
`endif
    repeat (5) step();

    chk("queue_empty", q.size(), 0);
    chk("idle_at_end", in_grant, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

endmodule
